ex_type_r_m: RTL and testbench

//  Execute stage for OP-opcode (R-type RV32I and RV32M) instructions. Consumes decoded

---
 rtl/ex_type_r_m.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ex_type_r_m.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_type_r_m.sv
// ex_type_r_m -- execute stage for OP-opcode instructions (RV32I R-type and RV32M).
//
// ALU and multiply ops produce a registered result one cycle after accept.
// DIV/DIVU/REM/REMU run on an iterative radix-2 restoring divider that
// operates on magnitudes. ready_o is held low while the divider is busy.
// Divide-by-zero and signed overflow are resolved in one cycle and do not
// use the divider.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous reset, active low
//   valid_i      in   ID presents an instruction
//   ready_o      out  EX can accept (accept = valid_i & ready_o & !flush_i)
//   flush_i      in   kill the accepted or in-flight op; no write-back for it
//   inst_i       in   raw instruction (opcode, funct3, funct7 are decoded)
//   op1_i/op2_i  in   rs1 / rs2 values
//   reg_we_i     in   ID write enable; 0 turns the accept into a bubble
//   reg_waddr_i  in   destination rd
//   valid_o      out  one-cycle pulse: write-back fields are valid
//   reg_we_o     out  register write enable, qualified by valid_o
//   reg_waddr_o  out  destination rd
//   reg_wdata_o  out  result

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef INST_TYPE_R_M
`define INST_TYPE_R_M 7'b0110011
`endif

module ex_type_r_m #(
  parameter int XLEN = `RDATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  input  logic [`DATA_WIDTH-1:0]  inst_i,
  input  logic [XLEN-1:0]         op1_i,
  input  logic [XLEN-1:0]         op2_i,
  input  logic                    reg_we_i,
  input  logic [`RADDR_WIDTH-1:0] reg_waddr_i,
  output logic                    valid_o,
  output logic                    reg_we_o,
  output logic [`RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [XLEN-1:0]         reg_wdata_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                    state_q, state_d;
  logic                      valid_q, valid_d;
  logic                      we_q, we_d;
  logic [`RADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  // Divider state: quot_q starts as |dividend| and fills with quotient bits
  // from the right as the dividend bits are shifted into rem_q.
  logic [XLEN-1:0]           rem_q, rem_d;
  logic [XLEN-1:0]           quot_q, quot_d;
  logic [XLEN-1:0]           divisor_q, divisor_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      neg_quot_q, neg_quot_d;
  logic                      neg_rem_q, neg_rem_d;
  logic                      is_rem_q, is_rem_d;
  logic [`RADDR_WIDTH-1:0]   rd_q, rd_d;

  // Decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal, is_mul_div, is_div, alt, accept, go;
  logic       unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign funct7      = inst_i[31:25];
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

  assign legal      = (opcode == `INST_TYPE_R_M) &&
                      (funct7 == 7'b0000000 || funct7 == 7'b0100000 ||
                       funct7 == 7'b0000001);
  assign is_mul_div = (funct7 == 7'b0000001);
  assign is_div     = is_mul_div & funct3[2];
  assign alt        = (funct7 == 7'b0100000);

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;
  assign go      = accept & legal & reg_we_i;

  // ALU
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_result;
  logic            slt, sltu;

  assign shamt = op2_i[SHW-1:0];
  assign slt   = $signed(op1_i) < $signed(op2_i);
  assign sltu  = op1_i < op2_i;

  always_comb begin
    alu_result = '0;
    case (funct3)
      3'b000:  alu_result = alt ? (op1_i - op2_i) : (op1_i + op2_i);
      3'b001:  alu_result = op1_i << shamt;
      3'b010:  alu_result = {{(XLEN-1){1'b0}}, slt};
      3'b011:  alu_result = {{(XLEN-1){1'b0}}, sltu};
      3'b100:  alu_result = op1_i ^ op2_i;
      3'b101:  alu_result = alt ? XLEN'($signed(op1_i) >>> shamt) : (op1_i >> shamt);
      3'b110:  alu_result = op1_i | op2_i;
      default: alu_result = op1_i & op2_i;
    endcase
  end

  // Multiplier: one 2*XLEN multiply on sign- or zero-extended operands covers
  // all four variants, since the low 2*XLEN bits of the product are exact.
  logic              a_signed, b_signed;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_result;

  assign a_signed   = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
  assign b_signed   = (funct3[1:0] == 2'b01);
  assign mul_a      = {{XLEN{a_signed & op1_i[XLEN-1]}}, op1_i};
  assign mul_b      = {{XLEN{b_signed & op2_i[XLEN-1]}}, op2_i};
  assign prod       = mul_a * mul_b;
  assign mul_result = (funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Divide setup and single-cycle special cases
  logic            div_signed, div_is_rem, div_zero, div_ovf, op1_neg, op2_neg;
  logic [XLEN-1:0] abs1, abs2, special_result;

  assign div_signed = ~funct3[0];
  assign div_is_rem = funct3[1];
  assign div_zero   = (op2_i == '0);
  assign div_ovf    = div_signed && (op1_i == MIN_NEG) && (op2_i == ALL_ONES);
  assign op1_neg    = div_signed & op1_i[XLEN-1];
  assign op2_neg    = div_signed & op2_i[XLEN-1];
  assign abs1       = op1_neg ? (-op1_i) : op1_i;
  assign abs2       = op2_neg ? (-op2_i) : op2_i;

  always_comb begin
    if (div_zero) special_result = div_is_rem ? op1_i : ALL_ONES;
    else          special_result = div_is_rem ? '0 : MIN_NEG;
  end

  // One restoring shift-subtract step
  logic [XLEN:0]   rem_shift, diff;
  logic            take;
  logic [XLEN-1:0] rem_step, quot_step, quot_fin, rem_fin;

  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, divisor_q};
  assign take      = ~diff[XLEN];
  assign rem_step  = take ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quot_step = {quot_q[XLEN-2:0], take};
  assign quot_fin  = neg_quot_q ? (-quot_step) : quot_step;
  assign rem_fin   = neg_rem_q ? (-rem_step) : rem_step;

  // Next state
  always_comb begin
    state_d    = state_q;
    valid_d    = 1'b0;
    we_d       = we_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    count_d    = count_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    is_rem_d   = is_rem_q;
    rd_d       = rd_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          if (is_div && !div_zero && !div_ovf) begin
            rem_d      = '0;
            quot_d     = abs1;
            divisor_d  = abs2;
            count_d    = CW'(XLEN);
            neg_quot_d = op1_neg ^ op2_neg;
            neg_rem_d  = op1_neg;
            is_rem_d   = div_is_rem;
            rd_d       = reg_waddr_i;
            state_d    = BUSY;
          end else begin
            valid_d = 1'b1;
            we_d    = 1'b1;
            waddr_d = reg_waddr_i;
            if (is_div)          wdata_d = special_result;
            else if (is_mul_div) wdata_d = mul_result;
            else                 wdata_d = alu_result;
          end
        end
      end
      default: begin  // BUSY
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d   = rem_step;
          quot_d  = quot_step;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = IDLE;
            valid_d = 1'b1;
            we_d    = 1'b1;
            waddr_d = rd_q;
            wdata_d = is_rem_q ? rem_fin : quot_fin;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      count_q    <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      count_q    <= count_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      is_rem_q   <= is_rem_d;
      rd_q       <= rd_d;
    end
  end

  assign valid_o     = valid_q;
  assign reg_we_o    = we_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_ex_type_r_m.sv
// Bench for ex_type_r_m: directed cases followed by randomized ops checked
// against an arithmetic reference model.
module tb_ex_type_r_m;

  logic        clk = 1'b0;
  logic        rst_n, valid_i, flush_i, reg_we_i;
  logic        ready_o, valid_o, reg_we_o;
  logic [31:0] inst_i, op1_i, op2_i, reg_wdata_o;
  logic [4:0]  reg_waddr_i, reg_waddr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_type_r_m dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .inst_i(inst_i), .op1_i(op1_i), .op2_i(op2_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .valid_o(valid_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [31:0] model(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    if (f7 != 7'h01) begin
      case (f3)
        3'd0: return (f7 == 7'h20) ? a - b : a + b;
        3'd1: return a << b[4:0];
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (ua < ub) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return (f7 == 7'h20) ? 32'(sa >>> b[4:0]) : a >> b[4:0];
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_long(input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    return (f7 == 7'h01) && f3[2] && (b != 0) &&
           !(!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one op and check its write-back (1 cycle, or 32 busy cycles for divides).
  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input string tag);
    logic [31:0] exp;
    int          busy;
    exp = model(f7, f3, a, b);
    @(negedge clk);
    inst_i = enc(f7, f3, 7'b0110011); op1_i = a; op2_i = b;
    reg_waddr_i = rd; reg_we_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    if (is_long(f7, f3, a, b)) begin
      busy = 0;
      while (ready_o === 1'b0 && busy < 40) begin
        busy++;
        @(negedge clk);
      end
      chk({tag, " busy_cycles"}, 32'(busy), 32'd32);
    end
    $display("op %s f7=%h f3=%0d a=%h b=%h -> wdata=%h exp=%h", tag, f7, f3, a, b,
             reg_wdata_o, exp);
    chk({tag, " valid_o"}, {31'd0, valid_o}, 32'd1);
    chk({tag, " wdata"}, reg_wdata_o, exp);
    chk({tag, " waddr"}, {27'd0, reg_waddr_o}, {27'd0, rd});
    chk({tag, " we"}, {31'd0, reg_we_o}, 32'd1);
    chk({tag, " ready_o"}, {31'd0, ready_o}, 32'd1);
  endtask

  // An accept that must not produce a write-back.
  task automatic bubble(input logic [31:0] inst, input logic we, input logic fl,
                        input string tag);
    @(negedge clk);
    inst_i = inst; op1_i = 32'd1; op2_i = 32'd2; reg_waddr_i = 5'd4;
    reg_we_i = we; flush_i = fl; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    $display("bubble %s -> valid_o=%b", tag, valid_o);
    chk({tag, " valid_o"}, {31'd0, valid_o}, 32'd0);
  endtask

  // Start DIV -7/2 and return in the cycle just after accept (T+1).
  task automatic start_div(input logic [4:0] rd);
    @(negedge clk);
    inst_i = enc(7'h01, 3'd4, 7'b0110011); op1_i = 32'hFFFF_FFF9; op2_i = 32'd2;
    reg_waddr_i = rd; reg_we_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  logic [6:0]  f7_tab [3] = '{7'h00, 7'h20, 7'h01};
  logic [31:0] ra, rb;
  logic [6:0]  rf7;
  logic [2:0]  rf3;
  bit          seen;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; reg_we_i = 1'b0;
    inst_i = '0; op1_i = '0; op2_i = '0; reg_waddr_i = '0;
    repeat (3) @(negedge clk);
    chk("reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset we", {31'd0, reg_we_o}, 32'd0);
    chk("reset waddr", {27'd0, reg_waddr_o}, 32'd0);
    chk("reset wdata", reg_wdata_o, 32'd0);
    chk("reset ready_o", {31'd0, ready_o}, 32'd1);
    rst_n = 1'b1;

    // ADD then verify the pulse is one cycle wide
    run_op(7'h00, 3'd0, 32'd5, 32'd7, 5'd3, "ADD");
    @(negedge clk);
    chk("ADD pulse end", {31'd0, valid_o}, 32'd0);

    run_op(7'h20, 3'd5, 32'h8000_0000, 32'd4, 5'd1, "SRA");
    run_op(7'h00, 3'd3, 32'd1, 32'hFFFF_FFFF, 5'd2, "SLTU");
    run_op(7'h01, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, "MULH");
    run_op(7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, "MULHU");
    run_op(7'h01, 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7, "MULHSU");
    run_op(7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, "DIV");
    run_op(7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, "REM");
    run_op(7'h01, 3'd5, 32'd9, 32'd0, 5'd10, "DIVU0");
    run_op(7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "REMOVF");

    // Back-to-back single-cycle ops
    @(negedge clk);
    inst_i = enc(7'h00, 3'd0, 7'b0110011); op1_i = 32'd100; op2_i = 32'd23;
    reg_waddr_i = 5'd12; reg_we_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    chk("B2B first", reg_wdata_o, 32'd123);
    inst_i = enc(7'h00, 3'd4, 7'b0110011); op1_i = 32'hF0F0_F0F0; op2_i = 32'hFFFF_0000;
    reg_waddr_i = 5'd13;
    @(negedge clk);
    valid_i = 1'b0;
    chk("B2B second valid", {31'd0, valid_o}, 32'd1);
    chk("B2B second", reg_wdata_o, 32'h0F0F_F0F0);
    chk("B2B second waddr", {27'd0, reg_waddr_o}, 32'd13);

    // Bubbles
    bubble(enc(7'h02, 3'd0, 7'b0110011), 1'b1, 1'b0, "bad funct7");
    bubble(enc(7'h00, 3'd0, 7'b0010011), 1'b1, 1'b0, "bad opcode");
    bubble(enc(7'h00, 3'd0, 7'b0110011), 1'b0, 1'b0, "we=0");
    bubble(enc(7'h00, 3'd0, 7'b0110011), 1'b1, 1'b1, "flush in accept");

    // Flush mid-divide at T+10
    start_div(5'd14);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush ready_o", {31'd0, ready_o}, 32'd1);
    chk("flush valid_o", {31'd0, valid_o}, 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (valid_o === 1'b1) seen = 1; end
    chk("flush no late valid", {31'd0, seen}, 32'd0);

    // Flush on the final divide step
    start_div(5'd15);
    repeat (31) @(negedge clk);
    chk("final step still busy", {31'd0, ready_o}, 32'd0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("final flush valid_o", {31'd0, valid_o}, 32'd0);
    chk("final flush ready_o", {31'd0, ready_o}, 32'd1);

    // Reset mid-divide at T+10
    start_div(5'd16);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst valid_o", {31'd0, valid_o}, 32'd0);
    chk("mid rst we", {31'd0, reg_we_o}, 32'd0);
    chk("mid rst waddr", {27'd0, reg_waddr_o}, 32'd0);
    chk("mid rst wdata", reg_wdata_o, 32'd0);
    chk("mid rst ready_o", {31'd0, ready_o}, 32'd1);
    rst_n = 1'b1;

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      rf7 = f7_tab[$urandom_range(0, 2)];
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op(rf7, rf3, ra, rb, 5'($urandom_range(1, 31)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
